// File: rtl/mask_ser_pkg.sv
// Shared types and constants for the mask stream serializer.
// Step table, mode encoding and beat-counter sizing live here.
package mask_ser_pkg;

  localparam int unsigned IP_W  = 1080;
  localparam int unsigned OP_W  = 20;
  localparam int unsigned STEP0 = 16;
  localparam int unsigned STEP1 = 32;
  localparam int unsigned STEP2 = 54;

  localparam int unsigned MAX_STEP = (STEP0 > STEP1) ? ((STEP0 > STEP2) ? STEP0 : STEP2)
                                                     : ((STEP1 > STEP2) ? STEP1 : STEP2);
  localparam int unsigned CNT_W    = $clog2(MAX_STEP + 1);

  typedef enum logic [1:0] {
    MODE_320     = 2'd0,
    MODE_640     = 2'd1,
    MODE_1080    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mask_mode_e;

  // Beats per word for a mode; the illegal mode is never latched, so its value is a don't-care.
  function automatic logic [CNT_W-1:0] step_of(input mask_mode_e mode);
    logic [CNT_W-1:0] step;
    case (mode)
      MODE_320:  step = CNT_W'(STEP0);
      MODE_640:  step = CNT_W'(STEP1);
      MODE_1080: step = CNT_W'(STEP2);
      default:   step = CNT_W'(1);
    endcase
    return step;
  endfunction

endpackage

// File: rtl/mask_ser_tap.sv
// Combinational beat gather: picks bit i*STEP of the (already shifted) active word for
// every output lane i, with STEP chosen by the latched mode.
module mask_ser_tap
  import mask_ser_pkg::*;
(
  input  logic [IP_W-1:0] data_i,
  input  mask_mode_e      mode_i,
  output logic [OP_W-1:0] beat_o
);

  logic [OP_W-1:0] tap0, tap1, tap2;
  // Only the tap positions are read here; the rest of the word reaches the taps by shifting.
  logic unused_data;

  assign unused_data = ^data_i;

  for (genvar i = 0; i < OP_W; i++) begin : g_tap
    assign tap0[i] = data_i[i * STEP0];
    assign tap1[i] = data_i[i * STEP1];
    assign tap2[i] = data_i[i * STEP2];
  end

  // Select the tap set for the latched mode.
  always_comb begin
    beat_o = '0;
    case (mode_i)
      MODE_320:  beat_o = tap0;
      MODE_640:  beat_o = tap1;
      MODE_1080: beat_o = tap2;
      default:   beat_o = '0;
    endcase
  end

endmodule

// File: rtl/mask_stream_serializer.sv
// Wide mask word to narrow beat serializer with one active shift register and one pending
// word, so consecutive words stream without bubbles.
// Optional feature: define MASK_SER_PARITY_EN to add out_parity and par_err_cnt.
module mask_stream_serializer
  import mask_ser_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IP_W-1:0] in_data,
  input  logic [1:0]      in_mode,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            err_mode
`ifdef MASK_SER_PARITY_EN
  ,
  output logic            out_parity,
  output logic [7:0]      par_err_cnt
`endif
);

  if (OP_W * STEP0 > IP_W || OP_W * STEP1 > IP_W || OP_W * STEP2 > IP_W ||
      STEP0 < 1 || STEP1 < 1 || STEP2 < 1) begin : g_param_check
    $fatal(1, "mask_stream_serializer: step table does not fit the word width");
  end

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [IP_W-1:0] act_q, act_d, pend_q, pend_d;
  mask_mode_e      mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic            pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            err_q, err_d;
  logic [OP_W-1:0] tap_beat;

  logic accept, legal, acc_ok, xfer, last_xfer, load_slot, load_pend, load_in, do_load;

  mask_ser_tap u_tap (
    .data_i (act_q),
    .mode_i (mode_q),
    .beat_o (tap_beat)
  );

  // Handshake decode; in_ready is registered, so nothing here reaches it combinationally.
  always_comb begin
    accept    = in_valid & in_ready_q;
    legal     = mask_mode_e'(in_mode) != MODE_ILLEGAL;
    acc_ok    = accept & legal & ~flush;
    xfer      = out_valid & out_ready;
    last_xfer = xfer & out_last;
    load_slot = (state_q == StIdle) | last_xfer;
    // in_ready is low whenever pending is full, so both sources never compete.
    load_pend = load_slot & pend_valid_q & ~flush;
    load_in   = load_slot & ~pend_valid_q & acc_ok;
    do_load   = load_pend | load_in;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state: leave SHIFT only when the last beat goes and nothing reloads.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (do_load) state_d = StShift;
      StShift: if (last_xfer && !do_load) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // FSM outputs; out_data is forced to zero whenever no beat is offered.
  always_comb begin
    out_valid = (state_q == StShift);
    out_data  = out_valid ? tap_beat : '0;
    out_last  = out_valid & (cnt_q == step_of(mode_q) - CNT_W'(1));
    busy      = out_valid | pend_valid_q;
    in_ready  = in_ready_q;
    err_mode  = err_q;
`ifdef MASK_SER_PARITY_EN
    out_parity = ^out_data;
`endif
  end

  // Next-state for the active/pending buffers, beat counter and pulses.
  always_comb begin
    act_d        = act_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;

    if (load_pend) begin
      act_d        = pend_q;
      mode_d       = pend_mode_q;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end else if (load_in) begin
      act_d  = in_data;
      mode_d = mask_mode_e'(in_mode);
      cnt_d  = '0;
    end else if (xfer) begin
      act_d = act_q >> 1;
      cnt_d = last_xfer ? '0 : cnt_q + CNT_W'(1);
    end

    // Active is busy and not completing: park the accepted word.
    if (acc_ok && !load_in) begin
      pend_d       = in_data;
      pend_mode_d  = mask_mode_e'(in_mode);
      pend_valid_d = 1'b1;
    end

    if (flush) begin
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end

    in_ready_d = ~pend_valid_d;
    err_d      = accept & ~legal & ~flush;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      in_ready_q   <= in_ready_d;
      err_q        <= err_d;
    end
  end

  // Wide data buffers need no reset: they are only observed while marked valid.
  always_ff @(posedge clk) begin
    act_q       <= act_d;
    mode_q      <= mode_d;
    pend_q      <= pend_d;
    pend_mode_q <= pend_mode_d;
  end

`ifdef MASK_SER_PARITY_EN
  logic [7:0] par_cnt_q, par_cnt_d;

  // Saturating count of dropped illegal-mode words.
  always_comb begin
    par_cnt_d = par_cnt_q;
    if (flush)                          par_cnt_d = '0;
    else if (err_d && par_cnt_q != 8'hFF) par_cnt_d = par_cnt_q + 8'd1;
  end

  // Illegal-drop counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) par_cnt_q <= '0;
    else        par_cnt_q <= par_cnt_d;
  end

  assign par_err_cnt = par_cnt_q;
`endif

endmodule
